// File: rtl/csa_accumulator.sv
// csa_accumulator: frame accumulator built on a 16-bit carry-skip adder.
// Sums a valid/ready stream of 16-bit operands modulo 2^16, tracks a sticky
// carry-out and a saturating beat count, and hands the frame result out on a
// second valid/ready handshake.

module carry_skip_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic        w_carry;
    logic        w_blk_carry;
    logic        w_blk_prop;
    logic        w_p;
    logic        w_g;

    // Four 4-bit ripple blocks; a block whose bits all propagate forwards its
    // incoming carry directly instead of waiting for the internal ripple.
    always_comb begin
        sum         = '0;
        w_carry     = cin;
        w_blk_carry = 1'b0;
        w_blk_prop  = 1'b0;
        w_p         = 1'b0;
        w_g         = 1'b0;
        for (int unsigned blk = 0; blk < 4; blk++) begin
            w_blk_carry = w_carry;
            w_blk_prop  = 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
                w_p              = a[blk*4+i] ^ b[blk*4+i];
                w_g              = a[blk*4+i] & b[blk*4+i];
                sum[blk*4+i]     = w_p ^ w_blk_carry;
                w_blk_carry      = w_g | (w_p & w_blk_carry);
                w_blk_prop       = w_blk_prop & w_p;
            end
            w_carry = w_blk_prop ? w_carry : w_blk_carry;
        end
        cout = w_carry;
    end

endmodule

module csa_accumulator #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_sum,
    output logic               out_carry,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [15:0]          r_acc;
    logic                 r_carry_flag;
    logic [COUNT_W-1:0]   r_count;

    logic [15:0]          w_sum;
    logic                 w_cout;
    logic                 w_accept;
    logic                 w_release;

    carry_skip_16bit u_adder (
        .a    (r_acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_release = (r_state == HOLD) && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, ACC: begin
                if (w_accept) begin
                    w_next_state = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = !rst && (r_state != HOLD);
        out_valid = (r_state == HOLD);
    end

    // Accumulator, sticky carry and saturating count; cleared on reset and on
    // the result handshake, updated only on accepted beats.
    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_acc        <= '0;
            r_carry_flag <= 1'b0;
            r_count      <= '0;
        end else if (w_accept) begin
            r_acc        <= w_sum;
            r_carry_flag <= r_carry_flag | w_cout;
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign out_sum   = r_acc;
    assign out_carry = r_carry_flag;
    assign out_count = r_count;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: a reference model pushes expected
// frame results into a queue as beats are driven; a monitor pops and compares
// on every result handshake.

module tb_csa_accumulator;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic [7:0]  n;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_carry;
    logic [7:0]  out_count;

    int checks;
    int errors;

    exp_t        sb[$];
    logic [15:0] m_sum;
    logic        m_carry;
    logic [7:0]  m_count;

    csa_accumulator #(.COUNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare each result handshake against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got sum=%h carry=%b count=%0d, none expected",
                         out_sum, out_carry, out_count);
            end else begin
                e = sb.pop_front();
                if (out_sum !== e.s || out_carry !== e.c || out_count !== e.n) begin
                    errors++;
                    $display("FAIL result: got sum=%h carry=%b count=%0d, want sum=%h carry=%b count=%0d",
                             out_sum, out_carry, out_count, e.s, e.c, e.n);
                end
            end
        end
    end

    task automatic model_clear();
        m_sum   = '0;
        m_carry = 1'b0;
        m_count = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat and wait (bounded) for the edge that accepts it.
    task automatic send_beat(input logic [15:0] d, input logic last);
        logic [16:0] t;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, want 1 within 50 cycles", in_ready);
        end
        step();
        t       = {1'b0, m_sum} + {1'b0, d};
        m_sum   = t[15:0];
        m_carry = m_carry | t[16];
        if (m_count != 8'hFF) m_count = m_count + 8'd1;
        if (last) begin
            sb.push_back('{s: m_sum, c: m_carry, n: m_count});
            model_clear();
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain: %0d results pending, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b sum=%h, want 0 0 0000",
                         in_ready, out_valid, out_sum);
            end
        end
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_sum !== 16'h0000 || out_count !== 8'd0 || out_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b sum=%h count=%0d carry=%b, want 1 0000 0 0",
                     in_ready, out_sum, out_count, out_carry);
        end
        step();
    endtask

    task automatic test_basic();
        send_beat(16'h0001, 1'b0);
        send_beat(16'h0002, 1'b0);
        send_beat(16'h0003, 1'b1);
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
        end
        wait_drain("basic");
    endtask

    task automatic test_skip_carry();
        send_beat(16'h5555, 1'b0);
        send_beat(16'hAAAA, 1'b0);
        checks++;
        if (out_sum !== 16'hFFFF || out_carry !== 1'b0) begin
            errors++;
            $display("FAIL skip_mid: sum=%h carry=%b, want ffff 0", out_sum, out_carry);
        end
        send_beat(16'h0001, 1'b0);
        send_beat(16'h0003, 1'b1);
        idle_inputs();
        wait_drain("skip");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(16'hFFFF, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h0007;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'hFFFF ||
                out_carry !== 1'b0 || out_count !== 8'd1) begin
                errors++;
                $display("FAIL bp_stable: valid=%b ready=%b sum=%h carry=%b count=%0d, want 1 0 ffff 0 1",
                         out_valid, in_ready, out_sum, out_carry, out_count);
            end
        end
        step();
        idle_inputs();
        out_ready = 1'b1;
        wait_drain("bp");
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0000) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b sum=%h, want 0 0000", out_valid, out_sum);
        end
        send_beat(16'h0007, 1'b1);
        idle_inputs();
        wait_drain("bp_next");
    endtask

    task automatic test_reset_mid_frame();
        send_beat(16'h0100, 1'b0);
        send_beat(16'h0200, 1'b0);
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        send_beat(16'h0005, 1'b1);
        idle_inputs();
        wait_drain("midrst");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            send_beat(16'h0001, (i == 299));
        end
        idle_inputs();
        checks++;
        if (out_count !== 8'd255 || out_sum !== 16'h012C) begin
            errors++;
            $display("FAIL sat_hold: count=%0d sum=%h, want 255 012c", out_count, out_sum);
        end
        wait_drain("sat");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_skip_carry();
        test_backpressure();
        test_reset_mid_frame();
        test_saturation();
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Sequential accumulator that sits directly downstream of the 16-bit carry-skip adder. It instantiates `carry_skip_16bit` as its only adder and feeds back its own registered sum as one operand. It accepts a stream of 16-bit operands over a valid/ready handshake and sums them modulo 2^16, tracking any carry-out and the operand count. At the end of each frame it presents the result on a second valid/ready handshake.

## Interface
- COUNT_W, default 8: width of the operand counter (saturating).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  16  operand.
- in_last  in  1  marks final beat of a frame; qualified by in_valid.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  16  frame sum mod 2^16.
- out_carry  out  1  sticky: at least one adder cout=1 during the frame.
- out_count  out  COUNT_W  beats accepted in the frame, saturating at 2^COUNT_W-1.

## Operation
- Datapath:
  - One `carry_skip_16bit` instance with a=acc, b=in_data, cin=0.
  - Its sum feeds the acc register; its cout is ORed into the carry_flag register.
  - No other adder is used for the data path.
- A beat is accepted when in_valid && in_ready.
- States:
  - IDLE: acc=0, carry_flag=0, count=0, in_ready=1.
    - Accepted beat without in_last -> ACC.
    - Accepted beat with in_last -> HOLD.
  - ACC: in_ready=1; each accepted beat updates acc, carry_flag and count.
    - in_last on an accepted beat -> HOLD.
  - HOLD: in_ready=0; out_valid=1; out_sum/out_carry/out_count hold the final values.
    - out_ready=1 -> IDLE, clearing acc, carry_flag and count in the same edge.
- Per accepted beat:
  - acc <= acc + in_data, low 16 bits.
  - carry_flag <= carry_flag | cout.
  - count <= count+1, holding at max once reached.
- in_data and in_last are ignored when the beat is not accepted, including any beat presented in HOLD.
- Outputs:
  - out_sum = acc, out_carry = carry_flag, out_count = count, at all times.
  - They are meaningful only while out_valid=1.
- in_ready = !rst && state != HOLD.

## Timing
- Reset: rst sampled high at a clk edge gives state=IDLE, acc=0, carry_flag=0, count=0.
  - Therefore out_valid=0, out_sum=0, out_carry=0, out_count=0.
  - in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-frame or during HOLD discards the partial or pending result; no output is produced for it.
- Latency: out_valid rises in the cycle after the edge that accepts the in_last beat.
- Throughput:
  - One beat per cycle within a frame.
  - One dead input cycle per frame: the HOLD cycle in which out_ready=1.
  - The next frame's first beat can be accepted in the cycle after the result handshake.
- Backpressure: while out_valid=1 && out_ready=0, out_sum, out_carry and out_count stay stable.
- out_valid deasserts on the edge where out_valid && out_ready.
- The adder path acc -> carry_skip_16bit -> acc must close in one clk period; there is no pipelining inside the adder.
- Wrap-around:
  - Sums wrap silently modulo 2^16; overflow is reported only via out_carry.
  - The counter saturates and never wraps.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_data=0x1234 -> in_ready=0, out_valid=0, out_sum=0x0000. After release, in_ready=1 and acc is still 0.
- Basic frame: beats 0x0001, 0x0002, 0x0003 (last), back-to-back -> one cycle after the 3rd beat, out_valid=1 with out_sum=0x0006, out_carry=0, out_count=3.
- Skip path and sticky carry: beats 0x5555, 0xAAAA, 0x0001, 0x0003 (last). The acc after 0xAAAA is 0xFFFF, which is all-propagate.
  - Expected: out_sum=0x0003, out_carry=1, out_count=4.
  - The carry stays 1 even though the final add produces no carry.
- Backpressure and single-beat frame: beat 0xFFFF with in_last=1 -> HOLD with out_sum=0xFFFF, out_carry=0, out_count=1.
  - Hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=0x0007: outputs stay stable, in_ready=0, and 0x0007 is not added.
  - Assert out_ready -> IDLE; the next frame 0x0007 (last) gives out_sum=0x0007.
- Reset mid-frame: beats 0x0100, 0x0200, then rst=1 for 1 cycle, then 0x0005 (last) -> out_sum=0x0005, out_count=1, out_carry=0.
- Counter saturation: 300 beats of 0x0001, the last with in_last=1 -> out_sum=0x012C, out_count=255, out_carry=0.
